// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response encodings and small helpers
// for the register-slave slice.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [1:0] resp_of(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_hold_reg.sv
// One-entry holder: captures a payload on load and
// keeps it flagged as held until cleared.
module axi4_lite_hold_reg
    import axi4_lite_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_held
);

    logic [W-1:0] r_q;
    logic         r_held;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= '0;
            r_held <= 1'b0;
        end else if (i_clear) begin
            r_held <= 1'b0;
        end else if (i_load) begin
            r_q    <= i_d;
            r_held <= 1'b1;
        end
    end

    assign o_q    = r_q;
    assign o_held = r_held;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank responder: N_REGS byte-strobed
// registers exported to fabric with per-register write pulses.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int N_BYTES    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int N_REGS     = 16,
    parameter logic [8*N_BYTES-1:0] RESET_VAL = '0
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [ADDR_WIDTH-1:0]       AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [8*N_BYTES-1:0]        WDATA,
    input  logic [N_BYTES-1:0]          WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [ADDR_WIDTH-1:0]       ARADDR,
    input  logic [2:0]                  ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [8*N_BYTES-1:0]        RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [N_REGS*8*N_BYTES-1:0] reg_q,
    output logic [N_REGS-1:0]           wr_pulse
);

    localparam int DW    = 8 * N_BYTES;
    localparam int OFF_W = $clog2(N_BYTES);
    localparam int IDX_W = $clog2(N_REGS);
    localparam int DEC_W = OFF_W + IDX_W;

    if (ADDR_WIDTH < DEC_W) begin : g_addr_chk
        $error("ADDR_WIDTH too narrow for N_REGS*N_BYTES");
    end
    if (N_BYTES != 4 && N_BYTES != 8) begin : g_bytes_chk
        $error("N_BYTES must be 4 or 8");
    end
    if (N_REGS < 2 || (N_REGS & (N_REGS - 1)) != 0) begin : g_regs_chk
        $error("N_REGS must be a power of two >= 2");
    end

    // Anything above the decoded field set means out of range.
    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> DEC_W) == '0;
    endfunction

    logic                  r_rdy_en;
    logic [DW-1:0]         r_regs [N_REGS];

    logic [ADDR_WIDTH-1:0] w_aw_addr;
    logic                  w_aw_held;
    logic [DW+N_BYTES-1:0] w_w_q;
    logic                  w_w_held;
    logic [DW-1:0]         w_wr_data;
    logic [N_BYTES-1:0]    w_wr_strb;
    logic [IDX_W-1:0]      w_aw_idx;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_aw_ok;
    logic                  w_ar_ok;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_unused;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_rdy_en <= 1'b0;
        else          r_rdy_en <= 1'b1;
    end

    assign AWREADY = r_rdy_en & ~w_aw_held;
    assign WREADY  = r_rdy_en & ~w_w_held;
    assign ARREADY = r_rdy_en & ~RVALID;

    assign w_aw_hs  = AWVALID & AWREADY;
    assign w_w_hs   = WVALID & WREADY;
    assign w_ar_hs  = ARVALID & ARREADY;
    assign w_commit = w_aw_held & w_w_held & ~BVALID;

    axi4_lite_hold_reg #(.W(ADDR_WIDTH)) u_aw_hold (
        .i_clk   (ACLK),
        .i_rst_n (ARESETn),
        .i_load  (w_aw_hs),
        .i_clear (w_commit),
        .i_d     (AWADDR),
        .o_q     (w_aw_addr),
        .o_held  (w_aw_held)
    );

    axi4_lite_hold_reg #(.W(DW + N_BYTES)) u_w_hold (
        .i_clk   (ACLK),
        .i_rst_n (ARESETn),
        .i_load  (w_w_hs),
        .i_clear (w_commit),
        .i_d     ({WSTRB, WDATA}),
        .o_q     (w_w_q),
        .o_held  (w_w_held)
    );

    assign w_wr_data = w_w_q[DW-1:0];
    assign w_wr_strb = w_w_q[DW +: N_BYTES];
    assign w_aw_idx  = w_aw_addr[OFF_W +: IDX_W];
    assign w_ar_idx  = ARADDR[OFF_W +: IDX_W];
    assign w_aw_ok   = f_in_range(w_aw_addr);
    assign w_ar_ok   = f_in_range(ARADDR);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < N_REGS; i++) r_regs[i] <= RESET_VAL;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (w_commit) begin
                BVALID <= 1'b1;
                BRESP  <= resp_of(w_aw_ok);
                if (w_aw_ok) begin
                    for (int k = 0; k < N_BYTES; k++) begin
                        if (w_wr_strb[k])
                            r_regs[w_aw_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
                    end
                    wr_pulse[w_aw_idx] <= 1'b1;
                end
            end else if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
        end
    end

    // Reads sample r_regs before any same-edge commit lands.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= w_ar_ok ? r_regs[w_ar_idx] : '0;
            RRESP  <= resp_of(w_ar_ok);
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_regq
        assign reg_q[g*DW +: DW] = r_regs[g];
    end

    assign w_unused = ^{AWPROT, ARPROT, w_aw_addr[OFF_W-1:0], ARADDR[OFF_W-1:0]};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: vector table of
// write/read pairs plus hand sequences for B stalls and reset.
module tb_axi4_lite_reg_slave;
    import axi4_lite_pkg::*;

    logic         ACLK;
    logic         ARESETn;
    logic [11:0]  AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [11:0]  ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [511:0] reg_q;
    logic [15:0]  wr_pulse;

    axi4_lite_reg_slave #(
        .N_BYTES    (4),
        .ADDR_WIDTH (12),
        .N_REGS     (16),
        .RESET_VAL  (32'h0)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWADDR   (AWADDR),
        .AWPROT   (AWPROT),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARPROT   (ARPROT),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  bresp;
        logic [15:0] pulse;
        logic [11:0] raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [511:0] act,
                         input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no handshake within 50 cycles", name);
    endtask

    task automatic send_aw(input logic [11:0] a, input int dly, output int hs);
        hs = -1;
        repeat (dly) @(negedge ACLK);
        AWADDR  = a;
        AWVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (AWREADY) begin
                hs = cyc;
                break;
            end
            @(negedge ACLK);
        end
        if (hs < 0) begin
            tmo("aw_handshake");
            AWVALID = 1'b0;
        end else begin
            @(posedge ACLK);
            @(negedge ACLK);
            AWVALID = 1'b0;
            check("awready_after_capture", AWREADY, 0);
        end
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                          input int dly, output int hs);
        hs = -1;
        repeat (dly) @(negedge ACLK);
        WDATA  = d;
        WSTRB  = s;
        WVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (WREADY) begin
                hs = cyc;
                break;
            end
            @(negedge ACLK);
        end
        if (hs < 0) begin
            tmo("w_handshake");
            WVALID = 1'b0;
        end else begin
            @(posedge ACLK);
            @(negedge ACLK);
            WVALID = 1'b0;
            check("wready_after_capture", WREADY, 0);
        end
    endtask

    task automatic wait_bv(output int c);
        c = -1;
        for (int i = 0; i < 50; i++) begin
            if (BVALID) begin
                c = cyc;
                break;
            end
            @(negedge ACLK);
        end
        if (c < 0) tmo("bvalid_wait");
    endtask

    task automatic finish_b(input int last_hs, input logic [1:0] bresp,
                            input logic [15:0] pulse);
        int c;
        wait_bv(c);
        if (c >= 0) begin
            check("b_latency", c, last_hs + 2);
            check("bresp", BRESP, bresp);
            check("wr_pulse", wr_pulse, pulse);
            BREADY = 1'b1;
            @(posedge ACLK);
            @(negedge ACLK);
            BREADY = 1'b0;
            check("bvalid_drop", BVALID, 0);
            check("wr_pulse_1cyc", wr_pulse, 0);
        end
    endtask

    task automatic do_write(input vec_t v);
        int ha, hw;
        fork
            send_aw(v.waddr, v.aw_dly, ha);
            send_w(v.wdata, v.wstrb, v.w_dly, hw);
        join
        finish_b((ha > hw) ? ha : hw, v.bresp, v.pulse);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [31:0] d,
                           input logic [1:0] r);
        int hs;
        hs = -1;
        ARADDR  = a;
        ARVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (ARREADY) begin
                hs = i;
                break;
            end
            @(negedge ACLK);
        end
        if (hs < 0) begin
            tmo("ar_handshake");
            ARVALID = 1'b0;
        end else begin
            @(posedge ACLK);
            @(negedge ACLK);
            ARVALID = 1'b0;
            check("rvalid", RVALID, 1);
            check("arready_busy", ARREADY, 0);
            check("rdata", RDATA, d);
            check("rresp", RRESP, r);
            RREADY = 1'b1;
            @(posedge ACLK);
            @(negedge ACLK);
            RREADY = 1'b0;
            check("rvalid_drop", RVALID, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, AWREADY, 0);
        check({tag, "_wready"}, WREADY, 0);
        check({tag, "_arready"}, ARREADY, 0);
        check({tag, "_bvalid"}, BVALID, 0);
        check({tag, "_rvalid"}, RVALID, 0);
        check({tag, "_resp"}, {BRESP, RRESP}, 0);
        check({tag, "_rdata"}, RDATA, 0);
        check({tag, "_regq"}, reg_q, 0);
        check({tag, "_pulse"}, wr_pulse, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] snap;
        int ha, hw, c;

        vecs[0] = '{12'h004, 32'hDEADBEEF, 4'hF, 0, 0, RESP_OKAY,   16'h0002, 12'h004, 32'hDEADBEEF, RESP_OKAY};
        vecs[1] = '{12'h008, 32'h11223344, 4'hF, 0, 3, RESP_OKAY,   16'h0004, 12'h008, 32'h11223344, RESP_OKAY};
        vecs[2] = '{12'h008, 32'hAABBCCDD, 4'h5, 3, 0, RESP_OKAY,   16'h0004, 12'h008, 32'h11BB33DD, RESP_OKAY};
        vecs[3] = '{12'h00C, 32'h0BADF00D, 4'hF, 2, 0, RESP_OKAY,   16'h0008, 12'h00C, 32'h0BADF00D, RESP_OKAY};
        vecs[4] = '{12'h014, 32'h0BADF00D, 4'hF, 1, 1, RESP_OKAY,   16'h0020, 12'h014, 32'h0BADF00D, RESP_OKAY};
        vecs[5] = '{12'h03F, 32'h12345678, 4'hF, 0, 0, RESP_OKAY,   16'h8000, 12'h03C, 32'h12345678, RESP_OKAY};
        vecs[6] = '{12'h040, 32'h55555555, 4'hF, 0, 0, RESP_SLVERR, 16'h0000, 12'h040, 32'h0,        RESP_SLVERR};
        vecs[7] = '{12'hFFC, 32'hFFFFFFFF, 4'hF, 1, 0, RESP_SLVERR, 16'h0000, 12'hFFC, 32'h0,        RESP_SLVERR};
        vecs[8] = '{12'h000, 32'hCAFEF00D, 4'h8, 0, 0, RESP_OKAY,   16'h0001, 12'h002, 32'hCA000000, RESP_OKAY};
        vecs[9] = '{12'h004, 32'hFFFFFFFF, 4'h0, 0, 0, RESP_OKAY,   16'h0002, 12'h004, 32'hDEADBEEF, RESP_OKAY};

        ARESETn = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;

        repeat (2) @(negedge ACLK);
        check_all_zero("reset");
        ARESETn = 1'b1;
        #1;
        check("first_cycle_ready", {AWREADY, WREADY, ARREADY}, 0);
        @(negedge ACLK);
        check("ready_after_first", {AWREADY, WREADY, ARREADY}, 3'b111);

        for (int i = 0; i < 10; i++) begin
            snap = reg_q;
            do_write(vecs[i]);
            if (vecs[i].bresp == RESP_SLVERR)
                check("oor_regq_unchanged", reg_q, snap);
            else
                check("regq_slice", reg_q[32*vecs[i].waddr[5:2] +: 32], vecs[i].rdata);
            do_read(vecs[i].raddr, vecs[i].rdata, vecs[i].rresp);
        end

        // Read captured on the same edge as a commit to reg 6.
        fork
            send_aw(12'h018, 0, ha);
            send_w(32'h77, 4'hF, 0, hw);
        join
        ARADDR  = 12'h018;
        ARVALID = 1'b1;
        check("same_edge_arready", ARREADY, 1);
        @(posedge ACLK);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("same_edge_rvalid", {RVALID, BVALID}, 2'b11);
        check("same_edge_old_data", RDATA, 0);
        RREADY = 1'b1;
        BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        RREADY = 1'b0;
        BREADY = 1'b0;
        do_read(12'h018, 32'h77, RESP_OKAY);

        // B stalled five cycles while a second write queues.
        fork
            send_aw(12'h020, 0, ha);
            send_w(32'h1, 4'hF, 0, hw);
        join
        wait_bv(c);
        check("stall_first_pulse", wr_pulse, 16'h0100);
        fork
            send_aw(12'h024, 0, ha);
            send_w(32'h2, 4'hF, 0, hw);
        join
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", {BVALID, BRESP}, {1'b1, RESP_OKAY});
            check("stall_no_commit", reg_q[32*9 +: 32], 0);
            check("stall_no_pulse", wr_pulse, 0);
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        BREADY = 1'b0;
        check("stall_gap", BVALID, 0);
        @(negedge ACLK);
        check("second_bvalid", {BVALID, BRESP}, {1'b1, RESP_OKAY});
        check("second_pulse", wr_pulse, 16'h0200);
        check("second_data", reg_q[32*9 +: 32], 32'h2);
        BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        BREADY = 1'b0;

        // Reset with an AW held; the orphan W afterwards must not commit.
        send_aw(12'h01C, 0, ha);
        ARESETn = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("post_reset_ready", {AWREADY, WREADY, ARREADY}, 0);
        @(negedge ACLK);
        send_w(32'h99, 4'hF, 0, hw);
        for (int i = 0; i < 4; i++) begin
            check("no_spurious_b", {BVALID, wr_pulse}, 0);
            @(negedge ACLK);
        end
        check("reset_regs_clear", reg_q, 0);
        send_aw(12'h01C, 0, ha);
        finish_b(ha, RESP_OKAY, 16'h0080);
        do_read(12'h01C, 32'h99, RESP_OKAY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
